rr_arbiter_n: RTL and testbench

Parametrised round-robin arbiter for N requesters, the next generation of the team's fixed 4-client arbiter. It adds a rotating-priority pointer, a registered one-hot grant with an encoded index, and grant hold while the owner keeps requesting. An optional hold-time limit forces rotation. It sits in front of any shared resource (bus, memory port, output queue) where clients raise a level request and own the resource while granted.

---
 rtl/rr_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/rr_arbiter_n.sv | 147 ++++++++++++++
 tb/tb_rr_arbiter_n.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Optional feature macro used by the arbiter: RR_ARB_HOLD_LIMIT_EN.
package rr_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Widest arbiter supported; the one-hot helper works at this width and
  // callers slice off the bits they need.
  localparam int unsigned MAX_N    = 32;
  localparam int unsigned MAX_IDXW = 5;

  function automatic logic [MAX_N-1:0] onehot_from_idx(input logic [MAX_IDXW-1:0] idx);
    logic [MAX_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first unmasked request at or
// after ptr, scanning upward and wrapping N-1 -> 0.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    pick_oh,
  output logic [IDXW-1:0] pick_idx,
  output logic            pick_any
);

  logic [N-1:0]     cand;
  logic [IDXW:0]    pos;
  logic [MAX_N-1:0] oh_full;
  logic             unused_oh;

  assign cand = req & ~mask;

  // Walk the candidates starting at ptr; the extra bit in pos keeps the
  // wrap correct for non-power-of-two N.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    pos      = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IDXW+1)'(i);
      if (pos >= (IDXW+1)'(N)) pos = pos - (IDXW+1)'(N);
      if (!pick_any && cand[pos[IDXW-1:0]]) begin
        pick_any = 1'b1;
        pick_idx = pos[IDXW-1:0];
      end
    end
  end

  assign oh_full   = onehot_from_idx(MAX_IDXW'(pick_idx));
  assign pick_oh   = pick_any ? oh_full[N-1:0] : '0;
  assign unused_oh = |oh_full;

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N level-requesting clients with registered
// one-hot grant, encoded owner index and grant hold while requesting.
// Define RR_ARB_HOLD_LIMIT_EN to add the HOLD_MAX forced-rotation limit
// and the hold_timeout pulse; otherwise an owner holds indefinitely.
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  parameter int IDXW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic            hold_timeout
);

  if (N < 2 || N > 32 || HOLD_MAX < 1) begin : g_bad_params
    $error("rr_arbiter_n: N must be 2..32 and HOLD_MAX >= 1");
  end

  arb_state_t      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            owner_req;
  logic            take_pick;

  logic [N-1:0]    pick_oh;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int HCW = $clog2(HOLD_MAX + 1);
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           timeout_q, timeout_d;
  logic           at_limit;
  assign at_limit = (hold_cnt_q == HCW'(HOLD_MAX));
`endif

  function automatic logic [IDXW-1:0] ptr_after(input logic [IDXW-1:0] idx);
    if (idx == IDXW'(N - 1)) return '0;
    return idx + IDXW'(1);
  endfunction

  assign owner_req = req[idx_q];

  // The current owner is masked out of the pick. When the owner is still
  // requesting this only matters for a forced rotation; when it released,
  // its request is already low, so the mask changes nothing.
  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .mask     (grant_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  // Next-state: keep, hand over to the pick, or go idle.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    take_pick = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) take_pick = 1'b1;
      end
      ARB_GRANT: begin
        if (owner_req) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
          if (at_limit && pick_any) begin
            take_pick = 1'b1;
            timeout_d = 1'b1;
          end else if (!at_limit) begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
`endif
        end else if (pick_any) begin
          take_pick = 1'b1;
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (take_pick) begin
      state_d = ARB_GRANT;
      grant_d = pick_oh;
      idx_d   = pick_idx;
      ptr_d   = ptr_after(pick_idx);
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_d = HCW'(1);
`endif
    end
  end

  // Registered state and outputs; reset clears everything regardless of req.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= |grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
  assign hold_timeout = timeout_q;
`else
  assign hold_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n (N=4, HOLD_MAX=4). Hold-limit
// expectations follow whether RR_ARB_HOLD_LIMIT_EN is defined.
module tb_rr_arbiter_n;

  localparam int N    = 4;
  localparam int HM   = 4;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic            hold_timeout;

  typedef struct {
    string           name;
    logic [N-1:0]    grant;
    logic            valid;
    logic [IDXW-1:0] idx;
    logic            to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  rr_arbiter_n #(.N(N), .HOLD_MAX(HM), .IDXW(IDXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam bit HL = 1'b1;
`else
  localparam bit HL = 1'b0;
`endif

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string nm, input logic r, input logic [N-1:0] q,
                      input logic [N-1:0] eg, input int ei, input logic et);
    exp_t e;
    rst     = r;
    req     = q;
    e.name  = nm;
    e.grant = eg;
    e.valid = (eg != '0);
    e.idx   = IDXW'(ei);
    e.to    = et;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the arbiter presents outputs every cycle, so pop one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (grant === e.grant && grant_valid === e.valid &&
            grant_idx === e.idx && hold_timeout === e.to) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got grant=%b valid=%b idx=%0d to=%b, want grant=%b valid=%b idx=%0d to=%b",
                   e.name, grant, grant_valid, grant_idx, hold_timeout,
                   e.grant, e.valid, e.idx, e.to);
        end
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    @(negedge clk);

    // Reset gating with all requests high, then first grant to client 0
    step("rst0", 1, 4'b1111, 4'b0000, 0, 0);
    step("rst1", 1, 4'b1111, 4'b0000, 0, 0);
    step("rst2", 1, 4'b1111, 4'b0000, 0, 0);
    step("first_grant", 0, 4'b1111, 4'b0001, 0, 0);

    // Staggered requests and successive releases
    step("stag_rst", 1, 4'b0000, 4'b0000, 0, 0);
    step("stag_r0", 0, 4'b0001, 4'b0001, 0, 0);
    step("stag_r1", 0, 4'b0011, 4'b0001, 0, 0);
    step("stag_r2", 0, 4'b0111, 4'b0001, 0, 0);
    step("stag_r3", 0, 4'b1111, 4'b0001, 0, 0);
    step("stag_d0", 0, 4'b1110, 4'b0010, 1, 0);
    step("stag_d1", 0, 4'b1100, 4'b0100, 2, 0);
    step("stag_d2", 0, 4'b1000, 4'b1000, 3, 0);
    step("stag_d3", 0, 4'b0000, 4'b0000, 3, 0);

    // Wrap-around: owner 3 releases to pending 0, then ptr=1 prefers 1 over 3
    step("wrap_own3", 0, 4'b1000, 4'b1000, 3, 0);
    step("wrap_hold3", 0, 4'b1001, 4'b1000, 3, 0);
    step("wrap_to0", 0, 4'b0001, 4'b0001, 0, 0);
    step("wrap_ptr1", 0, 4'b1010, 4'b0010, 1, 0);
    step("wrap_idle", 0, 4'b0000, 4'b0000, 1, 0);
    step("wrap_ptr2", 0, 4'b1010, 4'b1000, 3, 0);
    step("wrap_idle2", 0, 4'b0000, 4'b0000, 3, 0);

    // Simultaneous release of owner 0 and arrival of req2
    step("sim_own0", 0, 4'b0001, 4'b0001, 0, 0);
    step("sim_swap", 0, 4'b0100, 4'b0100, 2, 0);
    step("sim_idle", 0, 4'b0000, 4'b0000, 2, 0);

    // Reset mid-grant, then arbitration restarts from client 0
    step("mid_own1", 0, 4'b0010, 4'b0010, 1, 0);
    step("mid_hold1", 0, 4'b0010, 4'b0010, 1, 0);
    step("mid_rst", 1, 4'b0010, 4'b0000, 0, 0);
    step("mid_after", 0, 4'b0110, 4'b0010, 1, 0);
    step("mid_idle", 0, 4'b0000, 4'b0000, 1, 0);

    // Hold limit with two contending clients
    step("hl_rst", 1, 4'b0000, 4'b0000, 0, 0);
    begin
      logic [N-1:0] g_on [10];
      int           i_on [10];
      logic         t_on [10];
      g_on = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
               4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
      i_on = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
      t_on = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
      for (int k = 0; k < 10; k++) begin
        if (HL) step($sformatf("hl_rot%0d", k), 0, 4'b0011, g_on[k], i_on[k], t_on[k]);
        else    step($sformatf("hl_keep%0d", k), 0, 4'b0011, 4'b0001, 0, 0);
      end
    end
    // Sole requester keeps the grant past the limit with no pulse
    for (int k = 0; k < 6; k++) step($sformatf("hl_solo%0d", k), 0, 4'b0001, 4'b0001, 0, 0);
    step("hl_idle", 0, 4'b0000, 4'b0000, 0, 0);

    stim_done = 1'b1;
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Backstop so the run always ends
  initial begin
    #50000;
    $display("FAIL watchdog: got no finish by 50000, want finish");
    $fatal(1, "watchdog");
  end

endmodule
